// File: rtl/instruction_encoder_if.sv
// Handshake and memory-write bundle between a sequencer, the instruction
// encoder and the instruction memory write port.
interface instruction_encoder_if #(
    parameter int unsigned MEMORY_DEPTH = 64
);
    localparam int unsigned CW = $clog2(MEMORY_DEPTH) + 1;

    logic          Start;
    logic          InValid;
    logic          InReady;
    logic [3:0]    Mnemonic;
    logic [4:0]    Rs;
    logic [4:0]    Rt;
    logic [4:0]    Rd;
    logic [4:0]    Shamt;
    logic [5:0]    Funct;
    logic [15:0]   Immediate;
    logic [25:0]   Target;
    logic [31:0]   InstrWord;
    logic [31:0]   InstrAddr;
    logic          InstrWrite;
    logic          MemReady;
    logic [CW-1:0] WordCount;
    logic          Full;
    logic          Error;

    // Sequencer/memory side
    modport master (
        output Start, InValid, Mnemonic, Rs, Rt, Rd, Shamt, Funct, Immediate, Target, MemReady,
        input  InReady, InstrWord, InstrAddr, InstrWrite, WordCount, Full, Error
    );

    // Encoder side
    modport slave (
        input  Start, InValid, Mnemonic, Rs, Rt, Rd, Shamt, Funct, Immediate, Target, MemReady,
        output InReady, InstrWord, InstrAddr, InstrWrite, WordCount, Full, Error
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded MIPS instruction descriptions into machine words and writes
// them to consecutive instruction-memory word addresses.
module instruction_encoder #(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input logic                 clk,
    input logic                 reset,
    instruction_encoder_if.slave bus
);
    localparam int unsigned CW = $clog2(MEMORY_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   word_q;
    logic [31:0]   addr_q;
    logic          write_q;
    logic          error_q;
    logic [CW-1:0] count_q;

    logic          ready_c;
    logic          accept_c;
    logic          legal_c;
    logic [31:0]   enc_c;

    // Handshake: accept only while loading, never in a Start cycle, and only
    // when the output buffer is empty or draining this cycle.
    always_comb begin
        ready_c  = (state_q == LOAD) && !bus.Start && (!write_q || bus.MemReady);
        accept_c = bus.InValid && ready_c;
        legal_c  = (bus.Mnemonic <= 4'd9);
    end

    // Field packing for each mnemonic class; LUI forces the Rs field to zero.
    always_comb begin
        enc_c = 32'h0;
        case (bus.Mnemonic)
            4'd0:    enc_c = {6'h00, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct};
            4'd1:    enc_c = {6'h08, bus.Rs, bus.Rt, bus.Immediate};
            4'd2:    enc_c = {6'h0d, bus.Rs, bus.Rt, bus.Immediate};
            4'd3:    enc_c = {6'h0f, 5'd0, bus.Rt, bus.Immediate};
            4'd4:    enc_c = {6'h23, bus.Rs, bus.Rt, bus.Immediate};
            4'd5:    enc_c = {6'h2b, bus.Rs, bus.Rt, bus.Immediate};
            4'd6:    enc_c = {6'h04, bus.Rs, bus.Rt, bus.Immediate};
            4'd7:    enc_c = {6'h05, bus.Rs, bus.Rt, bus.Immediate};
            4'd8:    enc_c = {6'h02, bus.Target};
            4'd9:    enc_c = {6'h03, bus.Target};
            default: enc_c = 32'h0;
        endcase
    end

    // Session state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: Start restarts from anywhere; the last legal word fills the session.
    always_comb begin
        state_d = state_q;
        if (bus.Start) begin
            state_d = LOAD;
        end else if (state_q == LOAD && accept_c && legal_c
                     && count_q == CW'(MEMORY_DEPTH - 1)) begin
            state_d = FULL;
        end
    end

    // Output buffer, word counter and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= 32'h0;
            addr_q  <= BASE_ADDRESS;
            write_q <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
        end else if (bus.Start) begin
            word_q  <= 32'h0;
            addr_q  <= BASE_ADDRESS;
            write_q <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (accept_c && legal_c) begin
                word_q  <= enc_c;
                addr_q  <= BASE_ADDRESS + (32'(count_q) << 2);
                write_q <= 1'b1;
                count_q <= count_q + CW'(1);
            end else if (write_q && bus.MemReady) begin
                write_q <= 1'b0;
            end
            if (accept_c && !legal_c) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.InReady    = ready_c;
    assign bus.InstrWord  = word_q;
    assign bus.InstrAddr  = addr_q;
    assign bus.InstrWrite = write_q;
    assign bus.WordCount  = count_q;
    assign bus.Full       = (count_q == CW'(MEMORY_DEPTH));
    assign bus.Error      = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboarded bench for instruction_encoder: the driver queues the expected
// word/address on each legal accept; the monitor pops on every memory handoff.
module tb_instruction_encoder;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic clk;
    logic reset;

    instruction_encoder_if #(.MEMORY_DEPTH(DEPTH)) bus ();

    instruction_encoder #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare at each handoff, and require a stalled word to hold still
    bit          held = 1'b0;
    logic [31:0] held_word;
    logic [31:0] held_addr;
    always @(negedge clk) begin
        if (reset && bus.InstrWrite) begin
            if (held) begin
                check("stall_word_stable", bus.InstrWord, held_word);
                check("stall_addr_stable", bus.InstrAddr, held_addr);
            end
            if (bus.MemReady) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("handoff_word", bus.InstrWord, e.word);
                    check("handoff_addr", bus.InstrAddr, e.addr);
                end
            end else begin
                held      = 1'b1;
                held_word = bus.InstrWord;
                held_addr = bus.InstrAddr;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic set_fields(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [25:0] tgt);
        bus.Mnemonic  = mn;
        bus.Rs        = rs;
        bus.Rt        = rt;
        bus.Rd        = rd;
        bus.Shamt     = sh;
        bus.Funct     = fn;
        bus.Immediate = imm;
        bus.Target    = tgt;
    endtask

    // Present one description and complete its handshake; entered and left #1 after a posedge
    task automatic send(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] exp_word, input logic [31:0] exp_addr,
                        input bit legal, output int waits);
        exp_t e;
        bit   ok;
        set_fields(mn, rs, rt, rd, sh, fn, imm, tgt);
        bus.InValid = 1'b1;
        waits = 0;
        ok    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.InReady) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout mnemonic=%0d InReady=%b required=1", mn, bus.InReady);
        end else if (legal) begin
            e.word = exp_word;
            e.addr = exp_addr;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
    endtask

    // Start pulse with InValid also high: Start must win the cycle
    task automatic start_session();
        bus.Start   = 1'b1;
        bus.InValid = 1'b1;
        @(negedge clk);
        check("start_cycle_inready", 32'(bus.InReady), 32'd0);
        @(posedge clk);
        #1;
        bus.Start   = 1'b0;
        bus.InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inready"},   32'(bus.InReady),    32'd0);
        check({tag, "_write"},     32'(bus.InstrWrite), 32'd0);
        check({tag, "_word"},      bus.InstrWord,       32'h0);
        check({tag, "_addr"},      bus.InstrAddr,       BASE);
        check({tag, "_wordcount"}, 32'(bus.WordCount),  32'd0);
        check({tag, "_full"},      32'(bus.Full),       32'd0);
        check({tag, "_error"},     32'(bus.Error),      32'd0);
    endtask

    initial begin
        int w;
        reset       = 1'b0;
        bus.Start   = 1'b0;
        bus.InValid = 1'b0;
        bus.MemReady = 1'b1;
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);

        // Reset state, then IDLE must not accept even with InValid high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.InValid = 1'b1;
        @(negedge clk);
        check("idle_inready", 32'(bus.InReady), 32'd0);
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;

        // Single R_TYPE add $t0,$t1,$t2
        start_session();
        send(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 32'h012A4020, BASE, 1'b1, w);
        @(negedge clk);
        check("rtype_write",     32'(bus.InstrWrite), 32'd1);
        check("rtype_word",      bus.InstrWord,       32'h012A4020);
        check("rtype_wordcount", 32'(bus.WordCount),  32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rtype_write_drop", 32'(bus.InstrWrite), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back ADDI, LUI (Rs ignored), JAL at full throughput
        start_session();
        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 32'h20080005, BASE + 32'd0, 1'b1, w);
        check("b2b_addi_waits", 32'(w), 32'd0);
        send(4'd3, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001, 26'h0, 32'h3C011001, BASE + 32'd4, 1'b1, w);
        check("b2b_lui_waits", 32'(w), 32'd0);
        send(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0100005, 32'h0C100005, BASE + 32'd8, 1'b1, w);
        check("b2b_jal_waits", 32'(w), 32'd0);
        idle(2);

        // SW with memory stalled for three cycles; a queued ADDI must wait
        start_session();
        bus.MemReady = 1'b0;
        send(4'd5, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'h0, 32'hAFBFFFFC, BASE, 1'b1, w);
        set_fields(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0);
        bus.InValid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_inready", 32'(bus.InReady),    32'd0);
            check("stall_write",   32'(bus.InstrWrite), 32'd1);
            check("stall_word",    bus.InstrWord,       32'hAFBFFFFC);
            @(posedge clk);
            #1;
        end
        bus.MemReady = 1'b1;
        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 32'h20080005, BASE + 32'd4, 1'b1, w);
        check("drain_accept_waits", 32'(w), 32'd0);

        // Illegal mnemonic mid-stream: handshake completes, no write, count unchanged
        send(4'hC, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h1234, 26'h0, 32'h0, 32'h0, 1'b0, w);
        @(negedge clk);
        check("illegal_error",     32'(bus.Error),      32'd1);
        check("illegal_wordcount", 32'(bus.WordCount),  32'd2);
        check("illegal_write",     32'(bus.InstrWrite), 32'd0);
        @(posedge clk);
        #1;
        send(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'h0, 32'h342200FF, BASE + 32'd8, 1'b1, w);
        idle(2);
        check("error_sticky", 32'(bus.Error), 32'd1);
        start_session();
        @(negedge clk);
        check("restart_error",     32'(bus.Error),     32'd0);
        check("restart_wordcount", 32'(bus.WordCount), 32'd0);
        @(posedge clk);
        #1;

        // Fill all four slots: BEQ, BNE, LW, J
        send(4'd6, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, BASE + 32'd0, 1'b1, w);
        send(4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0, 32'h14640010, BASE + 32'd4, 1'b1, w);
        send(4'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, 32'h8FA80004, BASE + 32'd8, 1'b1, w);
        send(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000040, 32'h08000040, BASE + 32'd12, 1'b1, w);
        set_fields(4'd6, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0001, 26'h0);
        bus.InValid = 1'b1;
        @(negedge clk);
        check("full_flag",      32'(bus.Full),       32'd1);
        check("full_wordcount", 32'(bus.WordCount),  32'd4);
        check("full_inready",   32'(bus.InReady),    32'd0);
        check("full_write",     32'(bus.InstrWrite), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_inready_held", 32'(bus.InReady), 32'd0);
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        start_session();
        @(negedge clk);
        check("refill_wordcount", 32'(bus.WordCount), 32'd0);
        check("refill_full",      32'(bus.Full),      32'd0);
        @(posedge clk);
        #1;
        send(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 32'h012A4020, BASE, 1'b1, w);
        idle(2);

        // Reset while a write is stalled: everything returns to reset values at once
        bus.MemReady = 1'b0;
        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 32'h20080005, BASE + 32'd4, 1'b1, w);
        @(negedge clk);
        check("prereset_write", 32'(bus.InstrWrite), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        sb.delete();
        bus.MemReady = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_no_write", 32'(bus.InstrWrite), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3);
        check("post_reset_write", 32'(bus.InstrWrite), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
